// File: rtl/seg7_scan_driver.sv
// rtl/seg7_scan_driver.sv - multiplexed N-digit seven-segment scan driver with double-buffered frames
// Define SEG7_LZB_EN to enable leading-zero blanking.
module seg7_scan_driver #(
   parameter int NUM_DIGITS  = 8,
   parameter int REFRESH_DIV = 100000
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic [NUM_DIGITS*5-1:0] digits,
   input  logic [NUM_DIGITS-1:0]   dp_in,
   input  logic                    update,
   input  logic                    enable,
   output logic [NUM_DIGITS-1:0]   anodes,
   output logic [6:0]              segments,
   output logic                    dp,
   output logic                    frame_done
);
   localparam int IW = $clog2(NUM_DIGITS);
   localparam int CW = $clog2(REFRESH_DIV);
   localparam logic [IW-1:0] LAST_IDX = IW'(NUM_DIGITS - 1);
   localparam logic [CW-1:0] LAST_CNT = CW'(REFRESH_DIV - 1);

   logic [CW-1:0]           cnt;
   logic [IW-1:0]           idx;
   logic                    dirty;
   logic                    wrap_q;
   logic [NUM_DIGITS*5-1:0] pend_codes;
   logic [NUM_DIGITS-1:0]   pend_dp;
   logic [NUM_DIGITS*5-1:0] disp_codes;
   logic [NUM_DIGITS-1:0]   disp_dp;

   logic                    tc;
   logic                    wrap;
   logic [4:0]              code_arr [NUM_DIGITS];
   logic [NUM_DIGITS-1:0]   lzb;
   logic [4:0]              cur_code;
   logic [6:0]              seg_dec;
   logic [NUM_DIGITS-1:0]   anode_sel;

   assign tc   = enable && (cnt == LAST_CNT);
   assign wrap = tc && (idx == LAST_IDX);

   // Display buffer only changes on a wrap edge, so a frame never mixes old and new data.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         cnt        <= '0;
         idx        <= '0;
         dirty      <= 1'b0;
         wrap_q     <= 1'b0;
         pend_codes <= {NUM_DIGITS{5'h10}};
         pend_dp    <= '0;
         disp_codes <= {NUM_DIGITS{5'h10}};
         disp_dp    <= '0;
      end else begin
         wrap_q <= wrap;
         if (enable) begin
            if (tc) begin
               cnt <= '0;
               idx <= (idx == LAST_IDX) ? '0 : idx + IW'(1);
            end else begin
               cnt <= cnt + CW'(1);
            end
         end
         if (update) begin
            pend_codes <= digits;
            pend_dp    <= dp_in;
         end
         if (wrap && update) begin
            disp_codes <= digits;
            disp_dp    <= dp_in;
            dirty      <= 1'b0;
         end else if (wrap && dirty) begin
            disp_codes <= pend_codes;
            disp_dp    <= pend_dp;
            dirty      <= 1'b0;
         end else if (update) begin
            dirty <= 1'b1;
         end
      end
   end

   always_comb begin
      for (int i = 0; i < NUM_DIGITS; i++) begin
         code_arr[i] = disp_codes[5*i +: 5];
      end
   end

`ifdef SEG7_LZB_EN
   logic lead;

   // Walk down from the most significant digit; digit 0 is never a candidate.
   always_comb begin
      lead = 1'b1;
      lzb  = '0;
      for (int i = NUM_DIGITS - 1; i > 0; i--) begin
         lzb[i] = lead && (code_arr[i] == 5'h00);
         lead   = lead && ((code_arr[i] == 5'h00) || code_arr[i][4]);
      end
   end
`else
   assign lzb = '0;
`endif

   assign cur_code = lzb[idx] ? 5'h10 : code_arr[idx];

   always_comb begin
      seg_dec = 7'b1111111;
      case (cur_code)
         5'h00: seg_dec = 7'b0000001;
         5'h01: seg_dec = 7'b1001111;
         5'h02: seg_dec = 7'b0010010;
         5'h03: seg_dec = 7'b0000110;
         5'h04: seg_dec = 7'b1001100;
         5'h05: seg_dec = 7'b0100100;
         5'h06: seg_dec = 7'b0100000;
         5'h07: seg_dec = 7'b0001111;
         5'h08: seg_dec = 7'b0000000;
         5'h09: seg_dec = 7'b0000100;
         5'h0A: seg_dec = 7'b0001000;
         5'h0B: seg_dec = 7'b1100000;
         5'h0C: seg_dec = 7'b0110001;
         5'h0D: seg_dec = 7'b1000010;
         5'h0E: seg_dec = 7'b0110000;
         5'h0F: seg_dec = 7'b0111000;
         default: seg_dec = 7'b1111111;
      endcase
   end

   always_comb begin
      anode_sel      = '1;
      anode_sel[idx] = 1'b0;
   end

   // Outputs trail idx by one edge, so frame_done lands on the first digit-0 cycle.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         anodes     <= '1;
         segments   <= 7'b1111111;
         dp         <= 1'b1;
         frame_done <= 1'b0;
      end else begin
         frame_done <= wrap_q && enable;
         if (enable) begin
            anodes   <= anode_sel;
            segments <= seg_dec;
            dp       <= ~disp_dp[idx];
         end else begin
            anodes   <= '1;
            segments <= 7'b1111111;
            dp       <= 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_seg7_scan_driver.sv
// tb/tb_seg7_scan_driver.sv - scoreboard bench for seg7_scan_driver (4 digits, 4-cycle refresh)
module tb_seg7_scan_driver;
   localparam int ND = 4;
   localparam int RD = 4;
   localparam logic [6:0] BLANK = 7'b1111111;
   localparam logic [6:0] MAP [32] = '{
      7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110,
      7'b1001100, 7'b0100100, 7'b0100000, 7'b0001111,
      7'b0000000, 7'b0000100, 7'b0001000, 7'b1100000,
      7'b0110001, 7'b1000010, 7'b0110000, 7'b0111000,
      7'b1111111, 7'b1111111, 7'b1111111, 7'b1111111,
      7'b1111111, 7'b1111111, 7'b1111111, 7'b1111111,
      7'b1111111, 7'b1111111, 7'b1111111, 7'b1111111,
      7'b1111111, 7'b1111111, 7'b1111111, 7'b1111111
   };

   logic            clk = 1'b0;
   logic            rst_n;
   logic [ND*5-1:0] digits;
   logic [ND-1:0]   dp_in;
   logic            update;
   logic            enable;
   logic [ND-1:0]   anodes;
   logic [6:0]      segments;
   logic            dp;
   logic            frame_done;

   seg7_scan_driver #(.NUM_DIGITS(ND), .REFRESH_DIV(RD)) dut (
      .clk(clk), .rst_n(rst_n), .digits(digits), .dp_in(dp_in), .update(update),
      .enable(enable), .anodes(anodes), .segments(segments), .dp(dp), .frame_done(frame_done)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   typedef struct {
      int         cyc;
      logic [3:0] an;
      logic [6:0] seg;
      logic       dp;
      logic       fd;
      string      name;
   } exp_t;

   exp_t q[$];
   int   vectors = 0;
   int   miscompares = 0;
   logic flush = 1'b0;

   always @(negedge clk) begin : monitor
      exp_t e;
      while (q.size() > 0 && (flush || q[0].cyc <= cyc)) begin
         e = q.pop_front();
         vectors++;
         if (e.cyc != cyc) begin
            miscompares++;
            $display("FAIL %s never checked: due cyc=%0d, now cyc=%0d", e.name, e.cyc, cyc);
         end else if (anodes !== e.an || segments !== e.seg || dp !== e.dp || frame_done !== e.fd) begin
            miscompares++;
            $display("FAIL %s cyc=%0d got an=%b seg=%b dp=%b fd=%b want an=%b seg=%b dp=%b fd=%b",
                     e.name, cyc, anodes, segments, dp, frame_done, e.an, e.seg, e.dp, e.fd);
         end
      end
   end

   function automatic logic [3:0] an_of(int d);
      case (d)
         0: an_of = 4'b1110;
         1: an_of = 4'b1101;
         2: an_of = 4'b1011;
         default: an_of = 4'b0111;
      endcase
   endfunction

   task automatic push_one(int c, logic [3:0] an, logic [6:0] seg, logic dpv, logic fd, string nm);
      exp_t e;
      e.cyc = c; e.an = an; e.seg = seg; e.dp = dpv; e.fd = fd; e.name = nm;
      q.push_back(e);
   endtask

   task automatic push_frame(int s, logic [6:0] s0, logic [6:0] s1, logic [6:0] s2, logic [6:0] s3,
                             logic [3:0] dpn, logic fd0, string nm);
      logic [6:0] sg [4];
      sg[0] = s0; sg[1] = s1; sg[2] = s2; sg[3] = s3;
      for (int d = 0; d < 4; d++)
         for (int k = 0; k < 4; k++)
            push_one(s + 4*d + k, an_of(d), sg[d], dpn[d], (d == 0 && k == 0) ? fd0 : 1'b0, nm);
   endtask

   task automatic load(logic [4:0] d3, logic [4:0] d2, logic [4:0] d1, logic [4:0] d0, logic [3:0] dpv);
      digits = {d3, d2, d1, d0};
      dp_in  = dpv;
      update = 1'b1;
   endtask

   task automatic wait_cyc(int c);
      while (cyc < c) @(negedge clk);
   endtask

   logic [6:0] lz2, lz3;

   initial begin
      rst_n = 1'b0; enable = 1'b0; update = 1'b0; digits = '0; dp_in = '0;
`ifdef SEG7_LZB_EN
      lz2 = BLANK; lz3 = BLANK;
`else
      lz2 = MAP[0]; lz3 = MAP[0];
`endif
      for (int c = 1; c <= 3; c++) push_one(c, 4'b1111, BLANK, 1'b1, 1'b0, "reset");

      wait_cyc(3);
      rst_n = 1'b1; enable = 1'b1;
      load(5'd3, 5'd2, 5'd1, 5'd0, 4'b0000);
      push_frame(4, BLANK, BLANK, BLANK, BLANK, 4'b1111, 1'b0, "first_frame");
      push_frame(20, MAP[0], MAP[1], MAP[2], MAP[3], 4'b1111, 1'b1, "scan");
      push_frame(36, MAP[0], MAP[1], MAP[2], MAP[3], 4'b1111, 1'b1, "scan_old");
      wait_cyc(4); update = 1'b0;

      // update during digit 2 of the frame starting at 36
      wait_cyc(44);
      load(5'd7, 5'd6, 5'd5, 5'd4, 4'b0101);
      push_frame(52, MAP[4], MAP[5], MAP[6], MAP[7], 4'b1010, 1'b1, "tear_new");
      wait_cyc(45); update = 1'b0;

      // update on the wrap edge (posedge 67)
      wait_cyc(66);
      load(5'h0B, 5'h0A, 5'h09, 5'h08, 4'b0000);
      push_frame(68, MAP[8], MAP[9], MAP[10], MAP[11], 4'b1111, 1'b1, "coincident");
      wait_cyc(67); update = 1'b0;

      for (int c = 0; c < 32; c++) begin
         wait_cyc(84 + 16*c - 8);
         load(5'h10, 5'h10, 5'h10, 5'(c), 4'b0000);
         push_one(84 + 16*c, 4'b1110, MAP[c], 1'b1, 1'b1, "map");
         wait_cyc(84 + 16*c - 7); update = 1'b0;
      end

      wait_cyc(588);
      load(5'h0F, 5'h0E, 5'h0D, 5'h0C, 4'b0000);
      for (int k = 0; k < 4; k++) push_one(596 + k, 4'b1110, MAP[12], 1'b1, k == 0, "en_pre");
      for (int k = 600; k < 602; k++) push_one(k, 4'b1101, MAP[13], 1'b1, 1'b0, "en_pre");
      for (int k = 602; k < 612; k++) push_one(k, 4'b1111, BLANK, 1'b1, 1'b0, "en_dark");
      for (int k = 612; k < 614; k++) push_one(k, 4'b1101, MAP[13], 1'b1, 1'b0, "en_resume");
      for (int k = 614; k < 618; k++) push_one(k, 4'b1011, MAP[14], 1'b1, 1'b0, "en_resume");
      for (int k = 618; k < 622; k++) push_one(k, 4'b0111, MAP[15], 1'b1, 1'b0, "en_resume");
      push_one(622, 4'b1110, MAP[12], 1'b1, 1'b1, "en_wrap");
      wait_cyc(589); update = 1'b0;
      wait_cyc(601); enable = 1'b0;
      wait_cyc(611); enable = 1'b1;

      wait_cyc(630);
      load(5'd0, 5'd0, 5'd5, 5'd0, 4'b1000);
      push_frame(638, MAP[0], MAP[5], lz2, lz3, 4'b0111, 1'b1, "lzb");
      wait_cyc(631); update = 1'b0; dp_in = '0;

      // pending update must be discarded by a reset before the next wrap
      wait_cyc(657);
      load(5'd1, 5'd1, 5'd1, 5'd1, 4'b1111);
      push_one(660, 4'b1111, BLANK, 1'b1, 1'b0, "rst_mid");
      push_frame(661, BLANK, BLANK, BLANK, BLANK, 4'b1111, 1'b0, "post_rst");
      push_one(677, 4'b1110, BLANK, 1'b1, 1'b1, "post_rst_wrap");
      wait_cyc(658); update = 1'b0; dp_in = '0;
      wait_cyc(659); rst_n = 1'b0;
      wait_cyc(660); rst_n = 1'b1;

      wait_cyc(685);
      flush = 1'b1;
      wait_cyc(688);
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule

// File: doc/seg7_scan_driver.md
# seg7_scan_driver

Multiplexed N-digit seven-segment display driver: the parametrised successor to the single-digit 5-bit-code segment decoder. The block holds a double-buffered digit frame and time-multiplexes the digits onto one shared active-low segment bus with active-low digit anodes. It adds refresh timing, tear-free frame updates, per-digit decimal points and display enable. It sits between the datapath, which produces digit codes, and the board's display pins.

## Interface
- `NUM_DIGITS`, 8: number of digits scanned; legal range 2..16.
- `REFRESH_DIV`, 100000: clock cycles each digit stays lit; legal range ≥2.
- `clk` in 1: system clock; all logic is on the rising edge.
- `rst_n` in 1: reset, synchronous and active-low.
- `digits` in `NUM_DIGITS*5`: digit codes; digit *i* is `digits[5*i+4:5*i]`, and digit 0 is the rightmost.
- `dp_in` in `NUM_DIGITS`: decimal-point request per digit; 1 = lit.
- `update` in 1: single-cycle strobe that captures `digits`/`dp_in` into the pending buffer.
- `enable` in 1: 1 = scan and drive; 0 = display dark.
- `anodes` out `NUM_DIGITS`: digit select, active-low, one-cold while enabled.
- `segments` out 7: pattern {a,b,c,d,e,f,g} on [6:0], active-low.
- `dp` out 1: decimal point, active-low.
- `frame_done` out 1: one-cycle pulse when the scan wraps from digit `NUM_DIGITS-1` to digit 0.

## Operation
- **Code map:** `segments` per code, 0 = segment on.
  - 0x00 `0000001`, 0x01 `1001111`, 0x02 `0010010`, 0x03 `0000110`
  - 0x04 `1001100`, 0x05 `0100100`, 0x06 `0100000`, 0x07 `0001111`
  - 0x08 `0000000`, 0x09 `0000100`, 0x0A `0001000`, 0x0B `1100000`
  - 0x0C `0110001`, 0x0D `1000010`, 0x0E `0110000`, 0x0F `0111000`
  - 0x10..0x1F: blank, `1111111`.
- **Buffers:** pending buffer (codes + dp) and display buffer. `update` writes pending. At frame wrap, pending is copied to display only if `update` occurred since the last copy (dirty flag).
- **Update coinciding with wrap:** if `update` is high in the same cycle as a wrap, the incoming values go directly into the display buffer and the dirty flag clears.
- **Scan state:** refresh counter `cnt` runs 0..`REFRESH_DIV-1` and digit index `idx` runs 0..`NUM_DIGITS-1`. When `cnt` reaches its terminal count, `cnt` returns to 0 and `idx` increments, wrapping to 0. The wrap asserts `frame_done`.
- **Enable low:** `cnt` and `idx` hold. `anodes` go all-ones, `segments` go `1111111` and `dp` goes 1. `update` and buffering keep working.
- **Enable rising:** scanning resumes from the held `idx`/`cnt`.
- **Decode source:** only the display buffer drives the outputs. `anodes[idx]` = 0 and all other anodes = 1. `dp` = ~dp_buf[idx].

## Timing
- **Reset values** (first edge with `rst_n` = 0): `anodes` all ones, `segments` `1111111`, `dp` 1, `frame_done` 0, `cnt` 0, `idx` 0, both buffers = code 0x10 with dp 0, dirty flag 0.
- **Registered outputs:** all outputs are registered. The outputs for a new `idx` appear on the edge after the counter wraps, and each digit is lit for exactly `REFRESH_DIV` cycles.
- **`frame_done`:** high for the one cycle in which `anodes` first selects digit 0 of a new frame.
- **Update latency:** a pending update becomes visible on the first digit-0 slot following the next wrap, so the maximum latency is `NUM_DIGITS*REFRESH_DIV`+1 cycles. Frames never mix old and new data.
- **Reset mid-scan:** reset forces the reset values on the next edge and discards pending data.

## Configuration
- **`SEG7_LZB_EN`** (leading-zero blanking):
  - Defined: a digit whose display code is 0x00 renders blank when every higher-index digit is 0x00 or blank. Digit 0 is never blanked, and the decimal point is unaffected. This is combinational from the display buffer and adds no extra latency.
  - Undefined: every code decodes literally per the code map.

## Test plan
- **Reset:** hold `rst_n`=0 for 3 cycles → `anodes`=all ones, `segments`=`1111111`, `dp`=1, `frame_done`=0.
- **Scan:** `NUM_DIGITS`=4, `REFRESH_DIV`=4; `update` with codes {3,2,1,0} → `anodes` steps `1110`,`1101`,`1011`,`0111` every 4 cycles with `segments` `0000001`,`1001111`,`0010010`,`0000110`; `frame_done` pulses every 16 cycles.
- **Map:** sweep codes 0x00..0x1F on digit 0 → `segments` match the code map (0x0B → `1100000`, 0x15 → `1111111`).
- **Tear-free:** `update` at digit 2 mid-frame → digits 2 and 3 still show old data, and the new data appears from the next `frame_done` onward. A separate `update` coincident with wrap takes effect in that same new frame.
- **Enable:** drop `enable` for 10 cycles → display dark and `idx`/`cnt` frozen; on re-enable, scanning continues from the frozen digit with its remaining count.
- **LZB** (with `SEG7_LZB_EN`): codes {0,0,5,0} on digits 3..0 with `dp_in`[3]=1 → digit 3 blank with dp lit, digit 2 blank, digit 1 `0100100`, digit 0 `0000001`. Without the macro, digits 3 and 2 show `0000001`.
